// File: rtl/cap_sort_select.sv
// cap_sort_select: odd-even transposition sort of N_SM capacitor voltages, emits insertion mask + clamped count; ports clk, rst, start, vcap_flat, n_insert, i_dir -> busy, done, sel_mask, r_out (+ ov_mask when CAP_SORT_OVLIM_EN is defined)
module cap_sort_select #(
  parameter int N_SM = 5,
  parameter int VW = 12,
  parameter logic [VW-1:0] VMAX = VW'(4000),
  localparam int RW = $clog2(N_SM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_SM*VW-1:0] vcap_flat,
  input  logic [RW-1:0]    n_insert,
  input  logic             i_dir,
  output logic             busy,
  output logic             done,
  output logic [N_SM-1:0]  sel_mask,
  output logic [RW-1:0]    r_out
`ifdef CAP_SORT_OVLIM_EN
  ,
  output logic [N_SM-1:0]  ov_mask
`endif
);
  localparam int IW = $clog2(N_SM);
`ifdef CAP_SORT_OVLIM_EN
  localparam int KW = VW + 1;
`else
  localparam int KW = VW;
`endif
  typedef enum logic [1:0] {IDLE, SORT, SELECT} state_t;
  state_t state_q;
  logic [KW-1:0] key_q [N_SM];
  logic [KW-1:0] key_d [N_SM];
  logic [IW-1:0] idx_q [N_SM];
  logic [IW-1:0] idx_d [N_SM];
  logic [RW-1:0] phase_q, n_q, k;
  logic dir_q;
  logic [N_SM-1:0] mask_d;
`ifdef CAP_SORT_OVLIM_EN
  logic [N_SM-1:0] ov_d;
`endif
  always_comb begin
    key_d = key_q;
    idx_d = idx_q;
    // strict compares leave equal keys in place, keeping lower SM index first
    for (int p = 0; p < N_SM - 1; p++)
      if (p[0] == phase_q[0] && (dir_q ? key_q[p] > key_q[p+1] : key_q[p] < key_q[p+1])) begin
        key_d[p] = key_q[p+1];
        key_d[p+1] = key_q[p];
        idx_d[p] = idx_q[p+1];
        idx_d[p+1] = idx_q[p];
      end
    k = (n_q > RW'(N_SM)) ? RW'(N_SM) : n_q;
    mask_d = '0;
`ifdef CAP_SORT_OVLIM_EN
    ov_d = '0;
`endif
    for (int j = 0; j < N_SM; j++) begin
      if (RW'(j) < k) mask_d[idx_q[j]] = 1'b1;
`ifdef CAP_SORT_OVLIM_EN
      ov_d[idx_q[j]] = key_q[j][KW-1];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sel_mask <= '0;
      r_out <= '0;
      phase_q <= '0;
      n_q <= '0;
      dir_q <= 1'b0;
`ifdef CAP_SORT_OVLIM_EN
      ov_mask <= '0;
`endif
      for (int i = 0; i < N_SM; i++) begin
        key_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          for (int i = 0; i < N_SM; i++) begin
`ifdef CAP_SORT_OVLIM_EN
            // over-voltage flag as key MSB ranks such SMs above all normal ones
            key_q[i] <= {vcap_flat[i*VW +: VW] > VMAX, vcap_flat[i*VW +: VW]};
`else
            key_q[i] <= vcap_flat[i*VW +: VW];
`endif
            idx_q[i] <= IW'(i);
          end
          n_q <= n_insert;
          dir_q <= i_dir;
          phase_q <= '0;
          busy <= 1'b1;
          state_q <= SORT;
        end
        SORT: begin
          key_q <= key_d;
          idx_q <= idx_d;
          phase_q <= phase_q + 1'b1;
          if (phase_q == RW'(N_SM - 1)) state_q <= SELECT;
        end
        SELECT: begin
          sel_mask <= mask_d;
          r_out <= k;
`ifdef CAP_SORT_OVLIM_EN
          ov_mask <= ov_d;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cap_sort_select.sv
// tb_cap_sort_select: directed checks of cap_sort_select ranking, clamping, latency and control behaviour
module tb_cap_sort_select;
  localparam int N = 5;
  localparam int VW = 12;
  localparam int RW = 3;
  logic clk = 1'b0;
  logic rst, start, i_dir, busy, done;
  logic [N*VW-1:0] vcap_flat;
  logic [RW-1:0] n_insert, r_out;
  logic [N-1:0] sel_mask;
`ifdef CAP_SORT_OVLIM_EN
  logic [N-1:0] ov_mask;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  cap_sort_select #(.N_SM(N), .VW(VW), .VMAX(12'd1015)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vcap_flat(vcap_flat),
    .n_insert(n_insert),
    .i_dir(i_dir),
    .busy(busy),
    .done(done),
    .sel_mask(sel_mask),
    .r_out(r_out)
`ifdef CAP_SORT_OVLIM_EN
    ,
    .ov_mask(ov_mask)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*VW-1:0] pack(input int a, input int b, input int c, input int d, input int e);
    return {VW'(e), VW'(d), VW'(c), VW'(b), VW'(a)};
  endfunction
  // called at a negedge; returns at the negedge of the done cycle
  task automatic run(input string tag, input logic [N*VW-1:0] v, input logic [RW-1:0] n, input logic d,
                     input logic [N-1:0] em, input logic [RW-1:0] er);
    int m, b;
    vcap_flat = v;
    n_insert = n;
    i_dir = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vcap_flat = ~v;
    n_insert = ~n;
    i_dir = ~d;
    m = 0;
    b = 0;
    while (!done && m < 40) begin
      if (busy) b++;
      @(negedge clk);
      m++;
    end
    check({tag, ".lat"}, 32'(m), 32'd6);
    check({tag, ".busycyc"}, 32'(b), 32'd6);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".mask"}, 32'(sel_mask), 32'(em));
    check({tag, ".r"}, 32'(r_out), 32'(er));
  endtask
  initial begin
    int dn, first;
    logic [N-1:0] mk;
    rst = 1'b1;
    start = 1'b0;
    vcap_flat = '0;
    n_insert = '0;
    i_dir = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.mask", 32'(sel_mask), 32'd0);
    check("rst.r", 32'(r_out), 32'd0);
`ifdef CAP_SORT_OVLIM_EN
    check("rst.ov", 32'(ov_mask), 32'd0);
`endif
    run("t1", pack(1000, 980, 1020, 990, 1010), 3'd2, 1'b1, 5'b01010, 3'd2);
    @(negedge clk);
    check("t1.donepulse", 32'(done), 32'd0);
    check("t1.hold", 32'(sel_mask), 32'h0a);
    run("t2", pack(1000, 980, 1020, 990, 1010), 3'd3, 1'b0, 5'b10101, 3'd3);
    @(negedge clk);
    run("tie.up", pack(1000, 1000, 1000, 1000, 1000), 3'd2, 1'b1, 5'b00011, 3'd2);
    run("tie.dn", pack(1000, 1000, 1000, 1000, 1000), 3'd2, 1'b0, 5'b00011, 3'd2);
    run("clamp7", pack(1000, 980, 1020, 990, 1010), 3'd7, 1'b1, 5'b11111, 3'd5);
    run("zero", pack(1000, 980, 1020, 990, 1010), 3'd0, 1'b0, 5'b00000, 3'd0);
    run("ramp.up", pack(100, 200, 300, 400, 500), 3'd3, 1'b1, 5'b00111, 3'd3);
    run("ramp.dn", pack(100, 200, 300, 400, 500), 3'd1, 1'b0, 5'b10000, 3'd1);
    run("stab.dn", pack(500, 300, 500, 300, 500), 3'd2, 1'b0, 5'b00101, 3'd2);
    run("stab.up", pack(500, 300, 500, 300, 500), 3'd3, 1'b1, 5'b01011, 3'd3);
    // start while busy must be ignored
    @(negedge clk);
    vcap_flat = pack(100, 200, 300, 400, 500);
    n_insert = 3'd2;
    i_dir = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vcap_flat = pack(500, 400, 300, 200, 100);
    i_dir = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    first = -1;
    mk = '0;
    for (int c = 2; c < 30; c++) begin
      if (done) begin
        dn++;
        if (first < 0) begin
          first = c;
          mk = sel_mask;
        end
      end
      @(negedge clk);
    end
    check("ign.count", 32'(dn), 32'd1);
    check("ign.lat", 32'(first), 32'd6);
    check("ign.mask", 32'(mk), 32'h18);
    // reset three edges after start aborts the sort
    vcap_flat = pack(100, 200, 300, 400, 500);
    n_insert = 3'd3;
    i_dir = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.mask", 32'(sel_mask), 32'd0);
    check("abort.r", 32'(r_out), 32'd0);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("abort.quiet", 32'(dn), 32'd0);
    run("t6", pack(1000, 980, 1020, 990, 1010), 3'd4, 1'b1, 5'b11011, 3'd4);
`ifdef CAP_SORT_OVLIM_EN
    check("t6.ov", 32'(ov_mask), 32'h04);
`endif
    // back-to-back: second start lands on the done cycle
    run("b2b.a", pack(100, 200, 300, 400, 500), 3'd1, 1'b1, 5'b00001, 3'd1);
    run("b2b.b", pack(500, 400, 300, 200, 100), 3'd1, 1'b1, 5'b10000, 3'd1);
    @(negedge clk);
    check("end.done", 32'(done), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
